// File: rtl/fetch_ifid.sv
// fetch_ifid: instruction-fetch stage and IF/ID pipeline register for the
// 16-bit five-stage pipeline.
//
// Owns the PC and drives the instruction-memory address. Forwards the raw
// fetched word to the hazard detector. Loads IF/ID with either the fetched
// word or an injected NOP, tracks HALT, and counts stall cycles.
//
// Ports:
//   clk, rst           rising-edge clock, async active-high reset
//   NOP, PcStall       hazard detector controls (squash IF/ID, hold PC)
//   Redirect, RedirectPC  EX-stage taken branch/jump and its target
//   ImemData           combinational instruction-memory read data
//   ImemAddr           current PC
//   IF_Instr           fetched word, passed straight through
//   ID_Instr, ID_PcPlus2, ID_Valid  IF/ID register contents
//   Halted             fetch is parked on a HALT
//   StallCnt           saturating count of PcStall cycles taken in RUN
//
// state   | meaning
// --------+----------------------------------------------------------
// RUN     | fetching sequentially; honours stall/squash/redirect
// HALTED  | HALT was latched into IF/ID; PC frozen until a redirect
module fetch_ifid #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OP   = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NOP,
  input  logic        PcStall,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  input  logic [15:0] ImemData,
  output logic [15:0] ImemAddr,
  output logic [15:0] IF_Instr,
  output logic [15:0] ID_Instr,
  output logic [15:0] ID_PcPlus2,
  output logic        ID_Valid,
  output logic        Halted,
  output logic [15:0] StallCnt
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0]  state;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        is_halt;

  // PC+2 wraps naturally in 16 bits.
  assign pc_plus2 = pc + 16'd2;
  assign is_halt  = (ImemData[15:11] == HALT_OP);

  assign ImemAddr = pc;
  assign IF_Instr = ImemData;
  assign Halted   = (state == ST_HALTED);

  // Redirect outranks everything, including HALTED, so a branch/jump
  // resolved in EX is the only way out of the halted state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      ID_Instr   <= NOP_INSTR;
      ID_PcPlus2 <= 16'h0000;
      ID_Valid   <= 1'b0;
      StallCnt   <= 16'h0000;
    end else if (Redirect) begin
      state    <= ST_RUN;
      pc       <= RedirectPC;
      ID_Instr <= NOP_INSTR;
      ID_Valid <= 1'b0;
    end else if (state == ST_HALTED) begin
      ID_Instr <= NOP_INSTR;
      ID_Valid <= 1'b0;
    end else if (PcStall) begin
      ID_Instr <= NOP_INSTR;
      ID_Valid <= 1'b0;
      if (StallCnt != 16'hFFFF) begin
        StallCnt <= StallCnt + 16'd1;
      end
    end else if (NOP) begin
      // Shadow of a branch/jump: drop the word but keep fetching.
      pc       <= pc_plus2;
      ID_Instr <= NOP_INSTR;
      ID_Valid <= 1'b0;
    end else begin
      ID_Instr   <= ImemData;
      ID_Valid   <= 1'b1;
      ID_PcPlus2 <= pc_plus2;
      if (is_halt) begin
        state <= ST_HALTED;
      end else begin
        pc <= pc_plus2;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ifid.sv
module tb_fetch_ifid;

  logic        clk;
  logic        rst;
  logic        nop;
  logic        pc_stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [15:0] if_instr;
  logic [15:0] id_instr;
  logic [15:0] id_pc_plus2;
  logic        id_valid;
  logic        halted;
  logic [15:0] stall_cnt;

  logic [15:0] imem [0:255];

  fetch_ifid dut (
    .clk        (clk),
    .rst        (rst),
    .NOP        (nop),
    .PcStall    (pc_stall),
    .Redirect   (redirect),
    .RedirectPC (redirect_pc),
    .ImemData   (imem_data),
    .ImemAddr   (imem_addr),
    .IF_Instr   (if_instr),
    .ID_Instr   (id_instr),
    .ID_PcPlus2 (id_pc_plus2),
    .ID_Valid   (id_valid),
    .Halted     (halted),
    .StallCnt   (stall_cnt)
  );

  assign imem_data = imem[imem_addr[8:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    string       name;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pcp2;
    logic        valid;
    logic        hlt;
    logic [15:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares the DUT state after each edge against the entry the
  // driver queued for that edge.
  always @(posedge clk) begin
    exp_t e;
    cyc_cnt++;
    #2;
    while (exp_q.size() > 0 && exp_q[0].tag <= cyc_cnt) begin
      e = exp_q.pop_front();
      if (e.tag < cyc_cnt) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s.late: checked at cycle %0d expected cycle %0d", e.name, cyc_cnt, e.tag);
      end else begin
        chk({e.name, ".ImemAddr"},   imem_addr,   e.pc);
        chk({e.name, ".IF_Instr"},   if_instr,    imem[e.pc[8:1]]);
        chk({e.name, ".ID_Instr"},   id_instr,    e.instr);
        chk({e.name, ".ID_PcPlus2"}, id_pc_plus2, e.pcp2);
        chk({e.name, ".ID_Valid"},   {15'd0, id_valid}, {15'd0, e.valid});
        chk({e.name, ".Halted"},     {15'd0, halted},   {15'd0, e.hlt});
        chk({e.name, ".StallCnt"},   stall_cnt,   e.stall);
      end
    end
  end

  // Called at a negedge: applies inputs, queues the expected post-edge state,
  // then advances to the next negedge.
  task automatic step(input logic n, input logic s, input logic r, input logic [15:0] rpc,
                      input bit do_chk, input string nm,
                      input logic [15:0] epc, input logic [15:0] ei, input logic [15:0] ep2,
                      input logic ev, input logic eh, input logic [15:0] es);
    exp_t e;
    nop         = n;
    pc_stall    = s;
    redirect    = r;
    redirect_pc = rpc;
    if (do_chk) begin
      e.tag = cyc_cnt + 1;
      e.name = nm;
      e.pc = epc;
      e.instr = ei;
      e.pcp2 = ep2;
      e.valid = ev;
      e.hlt = eh;
      e.stall = es;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".ImemAddr"},   imem_addr,   16'h0000);
    chk({nm, ".ID_Instr"},   id_instr,    16'h0800);
    chk({nm, ".ID_PcPlus2"}, id_pc_plus2, 16'h0000);
    chk({nm, ".ID_Valid"},   {15'd0, id_valid}, 16'h0000);
    chk({nm, ".Halted"},     {15'd0, halted},   16'h0000);
    chk({nm, ".StallCnt"},   stall_cnt,   16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h4000 | 16'(i);
    imem[0]    = 16'h1111;
    imem[1]    = 16'h2222;
    imem[2]    = 16'h3333;
    imem[3]    = 16'h4444;
    imem[4]    = 16'h5555;
    imem[8]    = 16'h0000;   // HALT at 0x10
    imem[16]   = 16'h6666;   // 0x20
    rst = 1'b1; nop = 1'b0; pc_stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;

    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("pre_fetch.IF_Instr", if_instr, 16'h1111);
    @(negedge clk);   // rst low across a plain edge? no: inputs idle but check holds below
    // The edge just passed fetched 0x1111; account for it explicitly.
    chk("first_edge.ID_Instr", id_instr, 16'h1111);
    chk("first_edge.ImemAddr", imem_addr, 16'h0002);

    //    nop  stl  red  rpc       chk name        pc        instr     pcp2     v  h  stall
    step(1'b0,1'b0,1'b0,16'h0000, 1, "seq1",     16'h0004, 16'h2222, 16'h0004, 1, 0, 16'd0);
    step(1'b1,1'b1,1'b0,16'h0000, 1, "stall1",   16'h0004, 16'h0800, 16'h0004, 0, 0, 16'd1);
    step(1'b1,1'b1,1'b0,16'h0000, 1, "stall2",   16'h0004, 16'h0800, 16'h0004, 0, 0, 16'd2);
    step(1'b0,1'b0,1'b0,16'h0000, 1, "release",  16'h0006, 16'h3333, 16'h0006, 1, 0, 16'd2);
    step(1'b1,1'b0,1'b0,16'h0000, 1, "squash",   16'h0008, 16'h0800, 16'h0006, 0, 0, 16'd2);
    step(1'b0,1'b0,1'b0,16'h0000, 1, "seq2",     16'h000A, 16'h5555, 16'h000A, 1, 0, 16'd2);
    step(1'b1,1'b1,1'b1,16'h0040, 1, "redir_pri",16'h0040, 16'h0800, 16'h000A, 0, 0, 16'd2);
    step(1'b0,1'b0,1'b1,16'h0010, 1, "redir10",  16'h0010, 16'h0800, 16'h000A, 0, 0, 16'd2);
    step(1'b0,1'b0,1'b0,16'h0000, 1, "halt",     16'h0010, 16'h0000, 16'h0012, 1, 1, 16'd2);
    step(1'b0,1'b0,1'b0,16'h0000, 1, "halted1",  16'h0010, 16'h0800, 16'h0012, 0, 1, 16'd2);
    step(1'b0,1'b1,1'b0,16'h0000, 1, "halt_stl", 16'h0010, 16'h0800, 16'h0012, 0, 1, 16'd2);
    step(1'b0,1'b0,1'b1,16'h0020, 1, "unhalt",   16'h0020, 16'h0800, 16'h0012, 0, 0, 16'd2);
    step(1'b0,1'b0,1'b0,16'h0000, 1, "resume",   16'h0022, 16'h6666, 16'h0022, 1, 0, 16'd2);
    step(1'b0,1'b0,1'b1,16'h0010, 1, "redir10b", 16'h0010, 16'h0800, 16'h0022, 0, 0, 16'd2);
    step(1'b1,1'b0,1'b0,16'h0000, 1, "sq_halt",  16'h0012, 16'h0800, 16'h0022, 0, 0, 16'd2);
    step(1'b0,1'b0,1'b1,16'h0010, 1, "redir10c", 16'h0010, 16'h0800, 16'h0022, 0, 0, 16'd2);
    step(1'b0,1'b1,1'b0,16'h0000, 1, "stl_halt", 16'h0010, 16'h0800, 16'h0022, 0, 0, 16'd3);
    step(1'b0,1'b0,1'b0,16'h0000, 1, "halt2",    16'h0010, 16'h0000, 16'h0012, 1, 1, 16'd3);
    step(1'b0,1'b0,1'b1,16'hFFFE, 1, "to_fffe",  16'hFFFE, 16'h0800, 16'h0012, 0, 0, 16'd3);
    step(1'b0,1'b0,1'b0,16'h0000, 1, "wrap",     16'h0000, 16'h40FF, 16'h0000, 1, 0, 16'd3);
    step(1'b0,1'b0,1'b0,16'h0000, 1, "post_wrap",16'h0002, 16'h1111, 16'h0002, 1, 0, 16'd3);

    // One more unchecked fetch, then async reset between edges.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 65533; i++)
      step(1'b0,1'b1,1'b0,16'h0000, 0, "", 16'h0, 16'h0, 16'h0, 0, 0, 16'h0);
    step(1'b0,1'b1,1'b0,16'h0000, 1, "sat_fffe", 16'h0000, 16'h0800, 16'h0000, 0, 0, 16'hFFFE);
    step(1'b0,1'b1,1'b0,16'h0000, 1, "sat_ffff", 16'h0000, 16'h0800, 16'h0000, 0, 0, 16'hFFFF);
    step(1'b0,1'b1,1'b0,16'h0000, 1, "sat_hold", 16'h0000, 16'h0800, 16'h0000, 0, 0, 16'hFFFF);
    step(1'b0,1'b0,1'b0,16'h0000, 1, "sat_run",  16'h0002, 16'h1111, 16'h0002, 1, 0, 16'hFFFF);

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
